ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 19 +
 rtl/ram_arbiter_rr_priority_select.sv | 29 ++
 rtl/ram_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared types and defaults for the RAM arbiter
package ram_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_DATA_WIDTH    = 16;
  localparam int DEF_ADDRESS_WIDTH = 16;
  localparam int DEF_MAX_BURST     = 8;

  // Index width for a requester number; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_priority_select.sv
// rtl/ram_arbiter_rr_priority_select.sv - rotating-priority one-hot winner select
module rr_priority_select #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner
);

  logic [PTR_W:0] idx;
  logic           found;

  // Scan requesters starting at ptr, wrapping modulo N; first hit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(N)) idx = idx - (PTR_W+1)'(N);
      if (!found && req[idx[PTR_W-1:0]]) begin
        winner[idx[PTR_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin RAM port arbiter with locked bursts
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int MAX_BURST     = DEF_MAX_BURST
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               lock,
  input  logic [NUM_REQ-1:0]               wren,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rvalid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [ADDRESS_WIDTH-1:0]         ram_address,
  output logic [DATA_WIDTH-1:0]            ram_data,
  output logic                             ram_wren,
  input  logic [DATA_WIDTH-1:0]            ram_q,
  output logic                             busy
);

  localparam int PTR_W = ptr_width(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t         state, state_n;
  logic [PTR_W-1:0]   ptr, ptr_n, owner, owner_n, arb_ptr, win_idx;
  logic [CNT_W-1:0]   burst_cnt, cnt_n;
  logic [NUM_REQ-1:0] arb_winner, rvalid_q;
  logic               owner_active;

  function automatic logic [PTR_W-1:0] inc_idx(input logic [PTR_W-1:0] x);
    return (x == PTR_W'(NUM_REQ - 1)) ? '0 : x + PTR_W'(1);
  endfunction

  // An owner that drops req releases at once; arbitration then starts just past it.
  always_comb begin
    owner_active = (state == ST_OWNED) && req[owner];
    arb_ptr      = (state == ST_OWNED) ? inc_idx(owner) : ptr;
  end

  rr_priority_select #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_select (
    .req    (req),
    .ptr    (arb_ptr),
    .winner (arb_winner)
  );

  // Grant generation and next-state: serve the owner, otherwise round-robin.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    cnt_n   = burst_cnt;
    gnt     = '0;
    win_idx = '0;
    if (owner_active) begin
      gnt[owner] = 1'b1;
      if (burst_cnt >= CNT_W'(MAX_BURST - 1) || !lock[owner]) begin
        state_n = ST_IDLE;
        ptr_n   = inc_idx(owner);
        cnt_n   = '0;
      end else begin
        cnt_n = burst_cnt + CNT_W'(1);
      end
    end else begin
      gnt = arb_winner;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (arb_winner[i]) win_idx = PTR_W'(i);
      end
      state_n = ST_IDLE;
      ptr_n   = arb_ptr;
      cnt_n   = '0;
      if (|arb_winner) begin
        if (lock[win_idx] && (MAX_BURST > 1)) begin
          state_n = ST_OWNED;
          owner_n = win_idx;
          cnt_n   = CNT_W'(1);
        end else begin
          ptr_n = inc_idx(win_idx);
        end
      end
    end
    if (reset) gnt = '0;
  end

  // Arbiter state registers and one-cycle-delayed read valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      rvalid_q  <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      owner     <= owner_n;
      burst_cnt <= cnt_n;
      rvalid_q  <= gnt & ~wren;
    end
  end

  // RAM port mux driven from the granted requester's slice.
  always_comb begin
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        ram_address = address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        ram_data    = wdata[i*DATA_WIDTH +: DATA_WIDTH];
        ram_wren    = wren[i];
      end
    end
  end

  // A read issued just before reset must not report valid data during reset.
  assign rvalid = reset ? '0 : rvalid_q;
  assign rdata  = ram_q;
  assign busy   = (|gnt) || (state == ST_OWNED);

endmodule
